fifo_rptr_lvl: RTL and testbench
================================

// Module: fifo_rptr_lvl
// PURPOSE
//  Read-domain pointer and status block for the async FIFO, parametrised in depth.
//  Keeps binary and Gray read pointers, drives the RAM read address and read enable,
//  and flags empty/almost-empty. Also reports a fill-level estimate and a sticky underflow.
//  Sits in the rclk domain; rq2_wptr arrives from the 2-flop write-pointer synchroniser.
// PARAMETERS
//  ADDR_W     4  RAM address width; DEPTH = 2**ADDR_W; pointers are ADDR_W+1 bits
//  AEMPTY_TH  2  raempty asserted when level <= AEMPTY_TH; legal range 0..DEPTH-1
// PORTS
//  rclk        in   1         read clock, all state on rising edge
//  rrst_n      in   1         asynchronous active-low reset
//  rinc        in   1         pop request from read client
//  rq2_wptr    in   ADDR_W+1  synchronised Gray write pointer
//  clr_uflow   in   1         clears runderflow
//  rptr        out  ADDR_W+1  registered Gray read pointer (to write-domain synchroniser)
//  raddr       out  ADDR_W    RAM read address = rbin[ADDR_W-1:0]
//  ren         out  1         RAM read enable = rinc & ~rempty
//  rempty      out  1         registered empty flag
//  raempty     out  1         registered almost-empty flag
//  rlevel      out  ADDR_W+1  registered fill-level estimate, 0..DEPTH
//  runderflow  out  1         sticky: pop requested while empty
// BEHAVIOUR
//  Reset (async assert, sync release on rclk): rbin=0, rptr=0, rempty=1, raempty=1,
//   rlevel=0, runderflow=0. raddr=0 and ren=0 follow from this.
//  ren is combinational: ren = rinc & ~rempty. A pop with rempty=1 is ignored;
//   the pointer does not move.
//  Next-state values:
//   rbin_nxt = rbin + ren (mod 2**(ADDR_W+1)); rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1).
//  Every rclk edge loads rbin <= rbin_nxt and rptr <= rgray_nxt.
//   rptr changes at most one bit per cycle.
//  raddr = rbin[ADDR_W-1:0]: the address of the word being popped in the ren cycle.
//   Read data from the RAM is the client's concern.
//  Empty: rempty <= (rgray_nxt == rq2_wptr).
//   A pop that drains the last word gives rempty=1 on the next edge, so no extra read.
//  Level:
//   wbin = Gray-to-binary(rq2_wptr), computed combinationally (XOR-prefix from MSB).
//   lvl_nxt = wbin - rbin_nxt, mod 2**(ADDR_W+1).
//   rlevel <= lvl_nxt when lvl_nxt <= DEPTH, else DEPTH (clamp; only on a corrupt sync).
//   rlevel is a conservative under-estimate: the synchroniser makes it lag writes by 2+ rclk.
//  Almost-empty: raempty <= (lvl_nxt <= AEMPTY_TH).
//   rempty=1 always implies raempty=1, and both update on the same edge.
//  Underflow: runderflow <= runderflow_set | (runderflow & ~clr_uflow),
//   where runderflow_set = rinc & rempty. Set wins over a simultaneous clear.
//  Wrap-around:
//   - rbin wraps from 2**(ADDR_W+1)-1 to 0 and raddr wraps from DEPTH-1 to 0.
//   - The pointer MSB toggles every DEPTH pops.
//   - Full/empty disambiguation relies on the MSB; the level subtraction is modular,
//     so it stays correct across the wrap.
//  Reset mid-operation: all outputs return to reset values immediately on rrst_n low,
//   independent of rclk. Pending pops are lost.
//  rq2_wptr is treated as stable for the cycle; no other CDC logic lives in this block.
// TESTING (ADDR_W=4, AEMPTY_TH=2)
//  Reset, rinc=1, rq2_wptr=0 -> rempty=1, raempty=1, rlevel=0, ren=0, rptr=0;
//   runderflow=1 after the first edge.
//  rq2_wptr=5'b00011 (bin 2), no pops -> next edge: rempty=0, rlevel=2, raempty=1;
//   rq2_wptr=5'b00110 (bin 4) -> rlevel=4, raempty=0.
//  From level 4, rinc=1 for 4 cycles -> raddr 0,1,2,3 with ren=1;
//   rlevel 3,2,1,0; raempty=1 from rlevel=2; rempty=1 after the 4th pop; 5th rinc gives ren=0.
//  Write/read 40 words with random gaps -> raddr wraps 15->0, rptr MSB toggles at pop 16 and 32;
//   rptr Hamming distance per edge <= 1; rlevel matches the model at every edge.
//  rinc=1 & rempty=1 with clr_uflow=1 in the same cycle -> runderflow=1;
//   clr_uflow=1 next cycle with no pop -> runderflow=0.
//  Reset asserted mid-stream at level 3 -> all outputs return to reset values immediately.
//   After release with rq2_wptr held, rlevel is recomputed from rbin=0.

Source files
------------

// File: rtl/fifo_rptr_lvl_if.sv
// Read-side port bundle of the async FIFO read pointer block.
// The slave modport is the pointer block; the master modport is the read client.
interface fifo_rptr_lvl_if #(
    parameter int ADDR_W = 4
);
    logic              rinc;
    logic [ADDR_W:0]   rq2_wptr;
    logic              clr_uflow;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W-1:0] raddr;
    logic              ren;
    logic              rempty;
    logic              raempty;
    logic [ADDR_W:0]   rlevel;
    logic              runderflow;

    modport slave (
        input  rinc, rq2_wptr, clr_uflow,
        output rptr, raddr, ren, rempty, raempty, rlevel, runderflow
    );

    modport master (
        output rinc, rq2_wptr, clr_uflow,
        input  rptr, raddr, ren, rempty, raempty, rlevel, runderflow
    );
endinterface

// File: rtl/fifo_rptr_lvl.sv
// Read-domain pointer and status logic for the async FIFO: binary/Gray read pointer,
// RAM read address/enable, empty/almost-empty flags, fill level and sticky underflow.
module fifo_rptr_lvl #(
    parameter int ADDR_W    = 4,
    parameter int AEMPTY_TH = 2
) (
    input  logic           rclk,
    input  logic           rrst_n,
    fifo_rptr_lvl_if.slave rd
);
    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    logic [PW-1:0] rbin_q,  rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic          rempty_q,  rempty_d;
    logic          raempty_q, raempty_d;
    logic [PW-1:0] rlevel_q,  rlevel_d;
    logic          runderflow_q, runderflow_d;
    logic [PW-1:0] wbin;
    logic [PW-1:0] lvl_nxt;
    logic          ren;

    assign ren = rd.rinc & ~rempty_q;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(rd.rq2_wptr >> i);
        end
    end

    always_comb begin
        rbin_d       = rbin_q + {{ADDR_W{1'b0}}, ren};
        rgray_d      = rbin_d ^ (rbin_d >> 1);
        lvl_nxt      = wbin - rbin_d;
        rempty_d     = (rgray_d == rd.rq2_wptr);
        raempty_d    = (lvl_nxt <= PW'(AEMPTY_TH));
        // A level above DEPTH can only come from a corrupted synchronised pointer.
        rlevel_d     = (lvl_nxt > PW'(DEPTH)) ? PW'(DEPTH) : lvl_nxt;
        runderflow_d = (rd.rinc & rempty_q) | (runderflow_q & ~rd.clr_uflow);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rgray_q      <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            rlevel_q     <= '0;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rgray_q      <= rgray_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            rlevel_q     <= rlevel_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign rd.rptr       = rgray_q;
    assign rd.raddr      = rbin_q[ADDR_W-1:0];
    assign rd.ren        = ren;
    assign rd.rempty     = rempty_q;
    assign rd.raempty    = raempty_q;
    assign rd.rlevel     = rlevel_q;
    assign rd.runderflow = runderflow_q;
endmodule

// File: tb/tb_fifo_rptr_lvl.sv
// Scoreboard bench for fifo_rptr_lvl: a count-based read/write model predicts flags,
// level, pointer and popped addresses; two monitors compare against the DUT.
module tb_fifo_rptr_lvl;
    typedef struct {
        logic       e;
        logic       ae;
        logic [4:0] lvl;
        logic [4:0] rptr;
        logic       uf;
    } exp_t;

    logic rclk = 1'b0;
    logic rrst_n = 1'b1;
    fifo_rptr_lvl_if #(.ADDR_W(4)) rd ();

    fifo_rptr_lvl #(.ADDR_W(4), .AEMPTY_TH(2)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rd     (rd)
    );

    always #5 rclk = ~rclk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t st_q[$];
    int   rd_q[$];

    // model: total words written (as seen via rq2_wptr) and popped
    int   wcnt = 0;
    int   rcnt = 0;
    logic exp_empty = 1'b1;
    logic exp_uflow = 1'b0;
    logic exp_ren   = 1'b0;
    logic [4:0] prev_rptr = '0;

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One rclk cycle: drive inputs, predict the state after the next edge, advance.
    task automatic cycle(input bit rinc, input bit clr);
        exp_t e;
        int   d;
        bit   pop;
        rd.rinc      = rinc;
        rd.clr_uflow = clr;
        rd.rq2_wptr  = gray(wcnt);
        pop     = rinc && !exp_empty;
        exp_ren = pop;
        if (pop) rd_q.push_back(rcnt & 15);
        exp_uflow = (rinc && exp_empty) || (exp_uflow && !clr);
        if (pop) rcnt++;
        d         = (wcnt - rcnt) & 31;
        exp_empty = (d == 0);
        e.e    = exp_empty;
        e.ae   = (d <= 2);
        e.lvl  = (d > 16) ? 5'd16 : 5'(d);
        e.rptr = gray(rcnt);
        e.uf   = exp_uflow;
        st_q.push_back(e);
        @(posedge rclk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rempty"},     rd.rempty,     1);
        chk({tag, "_raempty"},    rd.raempty,    1);
        chk({tag, "_rlevel"},     rd.rlevel,     0);
        chk({tag, "_ren"},        rd.ren,        0);
        chk({tag, "_rptr"},       rd.rptr,       0);
        chk({tag, "_raddr"},      rd.raddr,      0);
        chk({tag, "_runderflow"}, rd.runderflow, 0);
    endtask

    task automatic do_reset(input string tag);
        rrst_n = 1'b0;
        #1;
        chk_reset(tag);
        st_q.delete();
        rd_q.delete();
        rcnt      = 0;
        exp_empty = 1'b1;
        exp_uflow = 1'b0;
        exp_ren   = 1'b0;
        prev_rptr = '0;
        @(posedge rclk);
        @(posedge rclk);
        #2;
        chk({tag, "_held_rempty"}, rd.rempty, 1);
        rrst_n = 1'b1;
    endtask

    // state monitor: every edge that has a prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge rclk);
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("rempty",     rd.rempty,     e.e);
                chk("raempty",    rd.raempty,    e.ae);
                chk("rlevel",     rd.rlevel,     e.lvl);
                chk("rptr",       rd.rptr,       e.rptr);
                chk("runderflow", rd.runderflow, e.uf);
                chk("rptr_hamming", int'($countones(rd.rptr ^ prev_rptr) <= 1), 1);
                prev_rptr = rd.rptr;
            end
        end
    end

    // read-port monitor: checks enable every cycle and the address of each pop
    initial begin
        forever begin
            @(negedge rclk);
            chk("ren", rd.ren, exp_ren);
            if (rd.ren) begin
                if (rd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL raddr_unexpected: got pop at %0d expected none", rd.raddr);
                end else begin
                    chk("raddr", rd.raddr, rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int budget;
        rd.rinc      = 1'b1;
        rd.clr_uflow = 1'b0;
        rd.rq2_wptr  = '0;
        #2;
        do_reset("rst0");
        cycle(1, 0);                            // pop on empty -> underflow

        wcnt = 2; cycle(0, 0);                  // level 2, almost empty
        cycle(0, 1);                            // clear underflow
        wcnt = 4; cycle(0, 0);                  // level 4
        repeat (4) cycle(1, 0);                 // raddr 0..3, drain to empty
        cycle(1, 0);                            // ignored pop
        cycle(1, 1);                            // set beats clear
        cycle(0, 1);                            // clear alone

        target = rcnt + 40;
        budget = 0;
        while (rcnt < target && budget < 600) begin
            if ($urandom_range(0, 1) == 1 && (wcnt - rcnt) < 16) wcnt++;
            cycle($urandom_range(0, 9) < 6, 1'($urandom_range(0, 7) == 0));
            budget++;
        end
        chk("rand_pops_done", int'(rcnt >= target), 1);

        wcnt = rcnt + 3;
        cycle(0, 0);
        cycle(0, 0);
        chk("pre_reset_level", rd.rlevel, 3);
        do_reset("rst1");
        repeat (3) cycle(0, 0);                 // level recomputed from rbin=0
        repeat (24) cycle($urandom_range(0, 1) == 1, 0);
        cycle(0, 0);

        chk("st_q_drained", st_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
